// File: rtl/z_event_logger_pkg.sv
// Shared constants and helpers for the z_event_logger block.
package z_event_logger_pkg;

    localparam int unsigned TS_W_DEF  = 8;
    localparam int unsigned DEPTH_DEF = 4;
    localparam int unsigned CNT_W_DEF = 8;

    // Pointer width needed to address a FIFO of the given depth.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    localparam int unsigned PTR_W = ptr_w(DEPTH_DEF);

endpackage

// File: rtl/z_event_logger_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with an explicit occupancy counter.
module sync_fifo
    import z_event_logger_pkg::*;
#(
    parameter int unsigned WIDTH = TS_W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int unsigned PW = ptr_w(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [PW:0]      occ_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (occ_q == '0);
    assign full    = (occ_q == (PW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_ptr_q];

    // Storage, pointers and occupancy; array cleared so dout reads 0 after reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                occ_q <= occ_q + 1'b1;
            end else if (do_pop && !do_push) begin
                occ_q <= occ_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/z_event_logger.sv
// Timestamps rising edges of z into a FIFO; keeps a saturating event count
// and a sticky overflow flag for dropped events.
module z_event_logger
    import z_event_logger_pkg::*;
#(
    parameter int unsigned TS_W  = TS_W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             z,
    input  logic             clr,
    input  logic             rd_ready,
    output logic             rd_valid,
    output logic [TS_W-1:0]  rd_data,
    output logic [CNT_W-1:0] count,
    output logic             overflow
);

    logic [TS_W-1:0]  ts_q;
    logic             z_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             evt;
    logic             pop;
    logic             drop;
    logic             fifo_empty;
    logic             fifo_full;

    assign evt  = z & ~z_q;
    assign pop  = rd_valid & rd_ready;
    assign drop = evt & fifo_full & ~pop;

    sync_fifo #(
        .WIDTH (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk   (Clk),
        .Rst   (Rst),
        .push  (evt),
        .din   (ts_q),
        .pop   (pop),
        .dout  (rd_data),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign rd_valid = ~fifo_empty;
    assign count    = count_q;
    assign overflow = ovf_q;

    // Next count/overflow: a coincident event or drop takes priority over clr.
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q | drop;
        if (clr) begin
            count_d = evt ? CNT_W'(1) : '0;
            ovf_d   = drop;
        end else if (evt && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Free-running timestamp, edge-detect history and status registers.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            ts_q    <= '0;
            z_q     <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            ts_q    <= ts_q + 1'b1;
            z_q     <= z;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_z_event_logger.sv
// Directed self-checking bench for z_event_logger (default parameters).
module tb_z_event_logger;

    logic       Clk = 1'b0;
    logic       Rst = 1'b1;
    logic       z = 1'b0;
    logic       clr = 1'b0;
    logic       rd_ready = 1'b0;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic [7:0] cnt;
    logic       overflow;

    int vectors = 0;
    int miscompares = 0;

    z_event_logger #(
        .TS_W  (8),
        .DEPTH (4),
        .CNT_W (8)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .z        (z),
        .clr      (clr),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .count    (cnt),
        .overflow (overflow)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
    endtask

    initial begin
        // Reset, then one long pulse
        do_reset();
        check("rst_valid", 32'(rd_valid), 0);
        check("rst_data", 32'(rd_data), 0);
        check("rst_count", 32'(cnt), 0);
        check("rst_ovf", 32'(overflow), 0);
        z = 1'b1;
        repeat (4) tick();
        z = 1'b0;
        tick();
        check("pulse_valid", 32'(rd_valid), 1);
        check("pulse_data", 32'(rd_data), 0);
        check("pulse_count", 32'(cnt), 1);
        check("pulse_ovf", 32'(overflow), 0);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("pulse_single", 32'(rd_valid), 0);

        // Timestamps 3 and 7
        do_reset();
        repeat (3) tick();
        z = 1'b1;
        tick();
        tick();
        z = 1'b0;
        tick();
        tick();
        z = 1'b1;
        tick();
        z = 1'b0;
        check("ts_head", 32'(rd_data), 3);
        check("ts_count", 32'(cnt), 2);
        rd_ready = 1'b1;
        tick();
        check("ts_second", 32'(rd_data), 7);
        check("ts_valid2", 32'(rd_valid), 1);
        tick();
        check("ts_drained", 32'(rd_valid), 0);
        rd_ready = 1'b0;

        // Overflow: five events at ts 0,2,4,6,8 into a depth-4 FIFO
        do_reset();
        for (int i = 0; i < 5; i++) begin
            z = 1'b1;
            tick();
            z = 1'b0;
            tick();
        end
        check("ovf_flag", 32'(overflow), 1);
        check("ovf_count", 32'(cnt), 5);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_count", 32'(cnt), 0);
        check("clr_ovf", 32'(overflow), 0);
        check("clr_valid", 32'(rd_valid), 1);
        check("clr_head", 32'(rd_data), 0);

        // Full FIFO: pop and push on the same edge (ts = 11)
        z = 1'b1;
        rd_ready = 1'b1;
        tick();
        z = 1'b0;
        rd_ready = 1'b0;
        check("fullpop_ovf", 32'(overflow), 0);
        check("fullpop_count", 32'(cnt), 1);
        check("fullpop_head", 32'(rd_data), 2);
        rd_ready = 1'b1;
        tick();
        check("drain_1", 32'(rd_data), 4);
        tick();
        check("drain_2", 32'(rd_data), 6);
        tick();
        check("drain_3", 32'(rd_data), 11);
        check("drain_3v", 32'(rd_valid), 1);
        tick();
        check("drain_empty", 32'(rd_valid), 0);
        rd_ready = 1'b0;

        // Timestamp wrap: 300 idle cycles, then stamp 300 mod 256 = 44
        do_reset();
        repeat (300) tick();
        z = 1'b1;
        tick();
        z = 1'b0;
        check("wrap_stamp", 32'(rd_data), 44);

        // Count saturation with continuous reading
        do_reset();
        rd_ready = 1'b1;
        for (int i = 0; i < 260; i++) begin
            z = 1'b1;
            tick();
            z = 1'b0;
            tick();
            if (i == 253) check("sat_254", 32'(cnt), 254);
        end
        check("sat_count", 32'(cnt), 255);
        check("sat_ovf", 32'(overflow), 0);
        rd_ready = 1'b0;

        // Mid-operation reset with 3 entries queued and overflow set
        do_reset();
        for (int i = 0; i < 5; i++) begin
            z = 1'b1;
            tick();
            z = 1'b0;
            tick();
        end
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        check("mid_ovf_pre", 32'(overflow), 1);
        check("mid_head_pre", 32'(rd_data), 2);
        z = 1'b1;
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        check("mid_valid", 32'(rd_valid), 0);
        check("mid_data", 32'(rd_data), 0);
        check("mid_count", 32'(cnt), 0);
        check("mid_ovf", 32'(overflow), 0);
        tick();
        z = 1'b0;
        check("mid_evt_valid", 32'(rd_valid), 1);
        check("mid_evt_stamp", 32'(rd_data), 0);
        check("mid_evt_count", 32'(cnt), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/z_event_logger.md
# z_event_logger

Downstream consumer of the sequence-detector output `z`. Detects each rising edge of `z` and stamps it with a free-running cycle counter. Queues the timestamps in a small FIFO for a valid/ready reader. Also keeps a saturating total event count and a sticky overflow flag, so detector activity can be read back after the fact instead of watched live.

## Interface
- `TS_W`, 8, timestamp width; the cycle counter wraps modulo 2^TS_W
- `DEPTH`, 4, number of FIFO entries; power of two, at least 2
- `CNT_W`, 8, width of the event counter; saturates at 2^CNT_W−1

- `Clk`  in  1  single clock; all state changes on the rising edge
- `Rst`  in  1  reset, synchronous and active-high
- `z`  in  1  detector output; level, sampled on `Clk`
- `clr`  in  1  synchronous clear of `count` and `overflow` only
- `rd_ready`  in  1  reader accepts the head entry this cycle
- `rd_valid`  out  1  FIFO not empty
- `rd_data`  out  TS_W  timestamp of the oldest queued event
- `count`  out  CNT_W  total rising edges seen since reset or `clr`
- `overflow`  out  1  sticky; set when an event is dropped because the FIFO is full

## Operation
- Reset (`Rst`=1 at an edge) clears everything:
  - `ts`, `z_q`, FIFO pointers and occupancy, `count` and `overflow` all go to 0.
  - Outputs then read `rd_valid`=0, `rd_data`=0, `count`=0, `overflow`=0.
  - `Rst` overrides `clr`, push and pop in the same cycle.
- `ts` increments by 1 every non-reset edge and wraps from 2^TS_W−1 to 0.
- Event condition: `z`=1 and `z_q`=0 at an edge.
  - `z_q` is updated to `z` every edge.
  - Because `z_q` resets to 0, a `z` already high at the first post-reset edge counts as an event.
  - A level held high counts once.
- On an event:
  - The pre-increment value of `ts` is pushed.
  - `count` increments unless it is saturated.
- Pop occurs when `rd_valid` and `rd_ready` are both high at an edge.
- Push is accepted if occupancy < DEPTH, or if occupancy = DEPTH and a pop happens in the same edge.
  - Otherwise the event is dropped and `overflow` is set.
  - `count` still increments on a dropped event.
- Simultaneous push and pop leaves occupancy unchanged; the write and read pointers both advance.
- `clr` handling:
  - `clr`=1 zeroes `count` and `overflow`. The FIFO, `ts` and `z_q` are untouched.
  - If an event coincides with `clr`, `count` becomes 1.
  - If a drop coincides with `clr`, `overflow` becomes 1.
  - New data wins over the clear.
- `rd_data` reads first-word-fall-through from the register array at the read pointer. It is don't-care while `rd_valid`=0, but must equal 0 after reset.
- Pointers are log2(DEPTH) bits wide and wrap naturally. Full and empty are derived from a separate occupancy counter, log2(DEPTH)+1 bits wide.

## Timing
- Event-to-output latency is 1 cycle. For an event detected at edge k, `rd_valid` rises and `count` updates right after edge k.
- Pop latency: after the popping edge, `rd_data` shows the next entry (or `rd_valid`=0) in the same cycle.
- `rd_valid` must not depend combinationally on `rd_ready`. All outputs are registered or decoded from registers only.
- No combinational path exists from `z` to any output.
- Throughput: one push and one pop per cycle.

## Structure
- Package `z_event_logger_pkg` holds the default `TS_W`, `DEPTH` and `CNT_W` constants and a `clog2`-based `PTR_W` localparam helper.
- The storage lives in one sub-module, `sync_fifo`:
  - parameters WIDTH and DEPTH
  - ports `push`, `din`, `pop`, `dout`, `empty`, `full`
  - uses the same `Clk`/`Rst`
- The top module holds the edge detector, `ts`, `count`, `overflow` and the push/drop decision.

## Test plan
- Reset then pulse: `Rst`=1 for 1 cycle, then `z`=1 for 4 cycles, then `z`=0 → exactly one entry, `rd_data`=0, `count`=1, `overflow`=0.
- Timestamps:
  - `rd_ready`=0; drive `z` high, low, high with rising edges at ts = 3 and 7.
  - → entries are 3 then 7.
  - → raising `rd_ready` for 2 cycles shows 3 and then 7, and `rd_valid` falls after the second pop.
- Overflow: 5 rising edges with `rd_ready`=0 and DEPTH=4 → 4 entries are kept, the 5th is dropped, `overflow`=1 and `count`=5. A subsequent `clr` gives `count`=0 and `overflow`=0 with the FIFO still holding 4 entries.
- Full with simultaneous pop: FIFO full, `rd_ready`=1 and a rising edge on the same cycle → push is accepted, occupancy stays 4, `overflow` stays 0.
- Wrap and saturate, using TS_W=8 and CNT_W=8:
  - run 300 cycles → `ts` wraps 255→0 and a stamp taken after the wrap reads 44.
  - 260 alternating `z` edges → `count` holds at 255.
- Mid-operation reset: with 3 entries queued and `overflow`=1, assert `Rst` for one edge → all outputs are 0, and the next event stamps ts=0.
